// File: rtl/icache_fetch_unit.sv
// icache_fetch_unit
//
// Direct-mapped, read-only instruction cache placed between the fetch-stage
// PC and a pipelined, multi-cycle main memory. A hit returns the 16-bit
// instruction combinationally in the same cycle. A miss stalls the fetch
// stage while the whole block is fetched one word per cycle, then the
// current PC is looked up again.
//
// Ports:
//   clk        - the only clock; all state changes on its rising edge
//   rst        - synchronous, active-high reset
//   fetch_req  - fetch stage wants the instruction at pc_addr
//   pc_addr    - byte address: tag [15:9], index [8:4], word [3:1]; bit 0 ignored
//   instr      - instruction word on a hit, 16'h0000 otherwise
//   stall      - freeze PC and IF/ID
//   mem_req    - word read request to main memory
//   mem_addr   - word-aligned request address (16'h0000 when not requesting)
//   mem_data   - word returned by main memory
//   mem_valid  - mem_data is valid this cycle (responses return in request order)

module icache_fetch_unit #(
    parameter int NUM_BLOCKS      = 32,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [15:0] pc_addr,
    output logic [15:0] instr,
    output logic        stall,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        mem_valid
);

    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int TAG_W = 15 - IDX_W - OFF_W;
    localparam int ISS_W = OFF_W + 1;

    localparam logic [ISS_W-1:0] ISS_DONE = ISS_W'(WORDS_PER_BLOCK);
    localparam logic [OFF_W-1:0] RCV_LAST = OFF_W'(WORDS_PER_BLOCK - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    logic [15:0]           data_mem [NUM_BLOCKS*WORDS_PER_BLOCK];
    logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] valid_bits;

    logic [0:0]       state;
    logic [15:0]      fill_base;
    logic [ISS_W-1:0] iss;
    logic [OFF_W-1:0] rcv;

    logic [TAG_W-1:0] pc_tag;
    logic [IDX_W-1:0] pc_idx;
    logic [OFF_W-1:0] pc_word;
    logic [IDX_W-1:0] fill_idx;
    logic             hit;
    logic             miss;
    logic             unused_pc_bit0;

    // Split the PC into tag / index / word-offset fields. The fill index is
    // taken from the latched block base, so a PC that wanders during a fill
    // cannot redirect where returning words land.
    assign pc_tag         = pc_addr[15 -: TAG_W];
    assign pc_idx         = pc_addr[OFF_W+1 +: IDX_W];
    assign pc_word        = pc_addr[1 +: OFF_W];
    assign fill_idx       = fill_base[OFF_W+1 +: IDX_W];
    assign unused_pc_bit0 = pc_addr[0];

    assign hit  = fetch_req & valid_bits[pc_idx] & (tag_mem[pc_idx] == pc_tag);
    assign miss = fetch_req & ~hit;

    // Output decode. While filling, the stall is unconditional and the
    // issue side streams word requests until all words of the block have been
    // requested. In IDLE a hit is served straight out of the data array and a
    // miss raises stall in the very cycle it is detected.
    always_comb begin
        instr    = 16'h0000;
        stall    = 1'b0;
        mem_req  = 1'b0;
        mem_addr = 16'h0000;
        if (state == ST_FILL) begin
            stall = 1'b1;
            if (iss != ISS_DONE) begin
                mem_req  = 1'b1;
                mem_addr = fill_base + (16'(iss) << 1);
            end
        end else if (hit) begin
            instr = data_mem[{pc_idx, pc_word}];
        end else begin
            stall = fetch_req;
        end
    end

    // Control state: FSM, valid bits, issue and receive counters. The fill
    // ends on the last received word, never on the issue count, so the
    // memory latency can be anything. The issue and receive sides advance
    // independently, which lets a response coincide with the last request.
    // mem_valid outside FILL (e.g. stragglers after a reset) is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            valid_bits <= '0;
            fill_base  <= '0;
            iss        <= '0;
            rcv        <= '0;
        end else if (state == ST_IDLE) begin
            if (miss) begin
                fill_base          <= {pc_addr[15:OFF_W+1], {(OFF_W+1){1'b0}}};
                valid_bits[pc_idx] <= 1'b0;
                iss                <= '0;
                rcv                <= '0;
                state              <= ST_FILL;
            end
        end else begin
            if (iss != ISS_DONE) begin
                iss <= iss + 1'b1;
            end
            if (mem_valid) begin
                if (rcv == RCV_LAST) begin
                    valid_bits[fill_idx] <= 1'b1;
                    iss                  <= '0;
                    rcv                  <= '0;
                    state                <= ST_IDLE;
                end else begin
                    rcv <= rcv + 1'b1;
                end
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone decide
    // whether their contents count. The tag is written as soon as a miss is
    // seen, while the line's valid bit is being cleared in the same edge.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_IDLE && miss) begin
            tag_mem[pc_idx] <= pc_tag;
        end
        if (!rst && state == ST_FILL && mem_valid) begin
            data_mem[{fill_idx, rcv}] <= mem_data;
        end
    end

endmodule

// File: tb/tb_icache_fetch_unit.sv
// tb_icache_fetch_unit
//
// Self-checking bench for icache_fetch_unit. A behavioural main memory
// returns (address ^ 16'hA5A5) after a programmable latency, in request
// order. Hit behaviour is checked from a table of vectors; misses, evictions,
// latency variation and reset during a fill are driven as hand-written
// sequences.

module tb_icache_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [15:0] pc_addr;
    logic [15:0] instr;
    logic        stall;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_data  = 16'h0000;
    logic        mem_valid = 1'b0;

    int total = 0;
    int bad   = 0;

    icache_fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_req (fetch_req),
        .pc_addr   (pc_addr),
        .instr     (instr),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_valid (mem_valid)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time memory responses.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main memory model. A request seen in cycle c is answered with mem_valid
    // during cycle c+mem_lat, so the DUT samples it on the edge closing that
    // cycle. Outstanding requests survive a DUT reset on purpose, producing
    // stray responses afterwards.
    int          mem_lat = 4;
    logic [15:0] q_addr[$];
    int          q_due[$];

    always @(negedge clk) begin
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            mem_valid = 1'b1;
            mem_data  = q_addr[0] ^ 16'hA5A5;
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            mem_valid = 1'b0;
            mem_data  = 16'h0000;
        end
        if (mem_req === 1'b1) begin
            q_addr.push_back(mem_addr);
            q_due.push_back(cyc + mem_lat);
        end
    end

    typedef struct {
        logic        req;
        logic [15:0] addr;
        logic        exp_stall;
        logic [15:0] exp_instr;
        logic        exp_mem_req;
    } vec_t;

    vec_t vecs[$];

    // Move to the start of the next cycle and drive the fetch inputs.
    task automatic applyStimulus(input logic req, input logic [15:0] addr);
        @(posedge clk);
        #1;
        fetch_req = req;
        pc_addr   = addr;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One-cycle hit: no stall, no memory traffic, the right word.
    task automatic check_hit(input string name, input logic [15:0] addr,
                             input logic [15:0] exp_instr);
        applyStimulus(1'b1, addr);
        @(negedge clk);
        checkOutput({name, "/stall"}, 16'(stall), 16'd0);
        checkOutput({name, "/instr"}, instr, exp_instr);
        checkOutput({name, "/mem_req"}, 16'(mem_req), 16'd0);
    endtask

    // Full miss: counts stall cycles until the hit, records every requested
    // address, then checks the penalty, the address stream and the word.
    task automatic run_miss(input string name, input logic [15:0] addr, input int lat,
                            input logic [15:0] exp_instr, input int exp_pen);
        logic [15:0] seen[$];
        logic [15:0] base;
        int          stalls;
        bit          done;
        stalls  = 0;
        done    = 1'b0;
        base    = {addr[15:4], 4'h0};
        mem_lat = lat;
        applyStimulus(1'b1, addr);
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (mem_req === 1'b1) seen.push_back(mem_addr);
            if (stall !== 1'b0) begin
                stalls++;
                @(posedge clk);
                #1;
            end else begin
                done = 1'b1;
            end
        end
        checkOutput({name, "/completed"}, 16'(done), 16'd1);
        checkOutput({name, "/penalty"}, 16'(stalls), 16'(exp_pen));
        checkOutput({name, "/instr"}, instr, exp_instr);
        checkOutput({name, "/req_count"}, 16'(seen.size()), 16'd8);
        for (int i = 0; i < seen.size() && i < 8; i++) begin
            checkOutput({name, "/mem_addr"}, seen[i], base + 16'(2 * i));
        end
    endtask

    initial begin
        // Hits across the freshly filled block 0x0000..0x000E plus an idle cycle.
        vecs.push_back('{1'b1, 16'h0002, 1'b0, 16'hA5A7, 1'b0});
        vecs.push_back('{1'b1, 16'h0004, 1'b0, 16'hA5A1, 1'b0});
        vecs.push_back('{1'b1, 16'h0006, 1'b0, 16'hA5A3, 1'b0});
        vecs.push_back('{1'b1, 16'h0008, 1'b0, 16'hA5AD, 1'b0});
        vecs.push_back('{1'b1, 16'h000A, 1'b0, 16'hA5AF, 1'b0});
        vecs.push_back('{1'b1, 16'h000C, 1'b0, 16'hA5A9, 1'b0});
        vecs.push_back('{1'b1, 16'h000E, 1'b0, 16'hA5AB, 1'b0});
        vecs.push_back('{1'b0, 16'h0004, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{1'b1, 16'h0001, 1'b0, 16'hA5A5, 1'b0});

        rst       = 1'b1;
        fetch_req = 1'b0;
        pc_addr   = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset/mem_req", 16'(mem_req), 16'd0);
        checkOutput("reset/mem_addr", mem_addr, 16'h0000);
        checkOutput("reset/instr", instr, 16'h0000);
        checkOutput("reset/stall", 16'(stall), 16'd0);

        run_miss("cold", 16'h0000, 4, 16'hA5A5, 13);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].req, vecs[i].addr);
            @(negedge clk);
            checkOutput($sformatf("vec%0d/stall", i), 16'(stall), 16'(vecs[i].exp_stall));
            checkOutput($sformatf("vec%0d/instr", i), instr, vecs[i].exp_instr);
            checkOutput($sformatf("vec%0d/mem_req", i), 16'(mem_req), 16'(vecs[i].exp_mem_req));
        end

        run_miss("evict", 16'h0200, 4, 16'hA7A5, 13);
        run_miss("refetch", 16'h0000, 4, 16'hA5A5, 13);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 16'(32'h40 + 2 * i));
            @(negedge clk);
            checkOutput("idle/mem_req", 16'(mem_req), 16'd0);
            checkOutput("idle/stall", 16'(stall), 16'd0);
        end

        run_miss("lat1", 16'h0012, 1, 16'hA5B7, 10);
        run_miss("lat7", 16'h7FF0, 7, 16'hDA55, 16);
        check_hit("keep1", 16'h001E, 16'hA5BB);
        check_hit("keep0", 16'h0000, 16'hA5A5);
        check_hit("keep31", 16'h7FFE, 16'hDA5B);

        // Reset in the third FILL cycle of a miss on 0x0400.
        mem_lat = 4;
        applyStimulus(1'b1, 16'h0400);
        @(negedge clk);
        checkOutput("midfill/miss_stall", 16'(stall), 16'd1);
        applyStimulus(1'b1, 16'h0400);
        @(negedge clk);
        checkOutput("midfill/req", 16'(mem_req), 16'd1);
        applyStimulus(1'b1, 16'h0400);
        applyStimulus(1'b1, 16'h0400);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midfill/stall", 16'(stall), 16'd1);
        applyStimulus(1'b0, 16'h0400);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midfill/req_after_rst", 16'(mem_req), 16'd0);
        checkOutput("midfill/addr_after_rst", mem_addr, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 16'h0400);
            @(negedge clk);
            checkOutput("stray/mem_req", 16'(mem_req), 16'd0);
            checkOutput("stray/stall", 16'(stall), 16'd0);
            checkOutput("stray/instr", instr, 16'h0000);
        end
        run_miss("postrst", 16'h0000, 4, 16'hA5A5, 13);
        run_miss("postrst31", 16'h7FF0, 4, 16'hDA55, 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_fetch_unit.md
# icache_fetch_unit

Direct-mapped, read-only instruction cache with a miss-fill state machine. Sits between the fetch stage PC and a multi-cycle, pipelined main memory, replacing the single-cycle instruction memory. On a hit it returns the 16-bit instruction in the same cycle. On a miss it stalls the fetch stage, fills the whole 16-byte block one word per cycle, then resumes.

## Interface
Parameters:
- `NUM_BLOCKS`, default 32: cache lines; index width = log2(NUM_BLOCKS) = 5.
- `WORDS_PER_BLOCK`, default 8: 16-bit words per line; 16-byte block, word offset = pc_addr[3:1].

Ports:
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `fetch_req` in 1: fetch stage wants the instruction at `pc_addr`.
- `pc_addr` in 16: byte address, bit 0 ignored. Fields: tag [15:9] (7 bits), index [8:4], word [3:1].
- `instr` out 16: instruction word; 16'h0000 whenever `stall`=1.
- `stall` out 1: freeze PC and IF/ID.
- `mem_req` out 1: word read request to main memory.
- `mem_addr` out 16: word-aligned request address.
- `mem_data` in 16: returned word.
- `mem_valid` in 1: `mem_data` is valid this cycle. Words return in request order with a fixed latency (4 cycles in the system).

## Operation
- Storage:
  - data array 32×8×16 bits;
  - tag array 32×7 bits;
  - valid array 32×1 bit.
- Hit = `fetch_req` & valid[index] & (tag[index] == pc tag), evaluated combinationally.
- FSM state IDLE:
  - On hit: `instr` = data[index][word], `stall`=0.
  - On `fetch_req` & ~hit: `stall`=1. Latch block base {pc_addr[15:4],4'b0} into `fill_base`. Write tag[index]. Clear valid[index]. Go to FILL.
  - `fetch_req`=0: `stall`=0, `instr`=16'h0000, no memory activity.
  - `mem_valid` is ignored in IDLE.
- FSM state FILL:
  - `stall`=1 throughout.
  - Issue counter `iss` (0..8): while `iss`<8, drive `mem_req`=1, `mem_addr`=fill_base + 2·iss, and increment `iss`. When `iss`=8, `mem_req`=0.
  - Receive counter `rcv` (0..7): on each `mem_valid`, write `mem_data` into data[fill index][rcv] and increment `rcv`.
  - On the 8th `mem_valid`: set valid[fill index], clear both counters, return to IDLE.
- Completion is decided by the receive count, never by issue count or a cycle count, so any memory latency works.
- `fetch_req` deasserting or `pc_addr` changing during FILL does not abort the fill. After returning to IDLE, the current `pc_addr` is looked up afresh. The fetch stage holds PC while stalled in normal operation.
- Replacement: the new block overwrites whatever line sits at its index. There is no write path from the CPU into the cache.

## Timing
- Reset (asserted on a clock edge):
  - all valid bits cleared; state IDLE; counters 0;
  - `mem_req`=0, `mem_addr`=16'h0000, `instr`=16'h0000.
  - `stall` follows `fetch_req` after reset, because every access is now a miss.
  - Tag and data arrays need not be cleared.
- Reset mid-FILL: same as above on that edge. The partially filled line stays invalid. Late `mem_valid` pulses are ignored.
- Hit latency: 0 cycles (combinational output from `pc_addr`).
- Miss timeline, miss detected in cycle t, memory latency L=4:
  - `mem_req` high in cycles t+1..t+8, addresses base+0..base+14;
  - data returns in cycles t+5..t+12;
  - state is IDLE at t+13, where the hit gives `stall`=0.
  - `stall` is high for cycles t..t+12: 13 cycles.
  - General penalty: 9+L cycles.
- `mem_valid` arriving in the same cycle as the last issue is legal. The receive path never depends on issue state.
- Only the filling index has its valid bit cleared during FILL. Other lines are unaffected.

## Test plan
- Cold miss: reset, then `fetch_req`=1, `pc_addr`=0x0000. The memory model returns addr^16'hA5A5 with L=4. Required:
  - `stall` high for exactly 13 cycles;
  - `mem_addr` sequence 0x0000..0x000E;
  - then `instr`=0xA5A5 with `stall`=0.
- Sequential hits after the fill: `pc_addr` steps 0x0002..0x000E. Required: `stall`=0 every cycle, `instr`=addr^0xA5A5, `mem_req` never asserted.
- Conflict eviction, after the first fill:
  - `pc_addr`=0x0200 (index 0, tag 1) → miss, refill from 0x0200..0x020E, `instr`=0xA7A5;
  - then `pc_addr`=0x0000 → miss again (13 stall cycles).
- Reset mid-fill: assert `rst` in the 3rd cycle of FILL. Required:
  - `mem_req`=0 from the next cycle;
  - stray `mem_valid` pulses cause no writes;
  - a fetch of 0x0000 afterwards misses and fills cleanly.
- Idle and variable latency:
  - `fetch_req`=0 for 10 cycles → no `mem_req`, `stall`=0.
  - Memory model with L=1, then L=7 → correct data each time, with penalties of 10 and 16 cycles.
